// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter in front of the write side of a 64x8 async FIFO.
//   Four requesters offer 8-bit beats. The winner owns the FIFO until the last
//   beat of its packet or until BURST_MAX beats have been written, whichever
//   comes first. The round-robin pointer then moves past the finished owner.
//   Every arbitration spends exactly one IDLE cycle, and no beat moves in it.
//   Optional build macro FIFO_WR_ARB_STATS_EN adds stat_beats0..stat_beats3.
//   These are saturating 16-bit per-requester beat counters.
module fifo_wr_arbiter #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic        clk_w,
  input  logic        reset_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_data_w,
  output logic [3:0]  grant,
  output logic        busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0] stat_beats0,
  output logic [15:0] stat_beats1,
  output logic [15:0] stat_beats2,
  output logic [15:0] stat_beats3
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Burst limit in the counter's own width so the end-of-burst compare is exact.
  localparam logic [6:0] BURST_MAX_C = 7'(BURST_MAX);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  owner_r;
  logic [1:0]  owner_nxt_s;
  logic [1:0]  rr_ptr_r;
  logic [6:0]  count_r;
  logic [3:0]  grant_r;
  logic        busy_r;
  logic        beat_s;
  logic        burst_end_s;
  logic [3:0]  ready_s;
  logic [7:0]  data_s;

  // First valid requester at or above ptr, wrapping past 3 back to 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [1:0] idx_v;
    logic [1:0] pick_v;
    pick_v = ptr;
    // Walk from the farthest candidate down so the nearest valid one wins.
    for (int k = 3; k >= 0; k--) begin
      idx_v = ptr + 2'(k);
      if (valid[idx_v]) begin
        pick_v = idx_v;
      end else begin
        pick_v = pick_v;
      end
    end
    return pick_v;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-state selection plus the combinational write-side handshake.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    beat_s      = 1'b0;
    burst_end_s = 1'b0;
    ready_s     = 4'b0000;
    data_s      = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt_s = ST_BURST;
          owner_nxt_s = rr_pick(req_valid, rr_ptr_r);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        ready_s = fifo_full ? 4'b0000 : onehot4(owner_r);
        data_s  = req_data[{owner_r, 3'b000} +: 8];
        beat_s  = req_valid[owner_r] & ~fifo_full;
        // Last beat and limit beat may coincide; either way the burst ends once.
        if (beat_s && (req_last[owner_r] || ((count_r + 7'd1) == BURST_MAX_C))) begin
          burst_end_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          burst_end_s = 1'b0;
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        owner_nxt_s = 2'd0;
      end
    endcase
  end

  assign req_ready   = ready_s;
  assign fifo_wr_en  = beat_s;
  assign fifo_data_w = data_s;
  assign grant       = grant_r;
  assign busy        = busy_r;

  // FSM state, owner, round-robin pointer, beat count and registered grant/busy.
  always_ff @(posedge clk_w or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      owner_r  <= 2'd0;
      rr_ptr_r <= 2'd0;
      count_r  <= 7'd0;
      grant_r  <= 4'b0000;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_BURST)) begin
        count_r <= 7'd0;
      end else if (beat_s) begin
        count_r <= count_r + 7'd1;
      end else begin
        count_r <= count_r;
      end
      if (burst_end_s) begin
        rr_ptr_r <= owner_r + 2'd1;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      grant_r <= (state_nxt_s == ST_BURST) ? onehot4(owner_nxt_s) : 4'b0000;
      busy_r  <= (state_nxt_s == ST_BURST);
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? 16'hFFFF : (val + 16'd1);
  endfunction

  logic [15:0] stat_r [4];

  // Per-requester saturating count of beats written to the FIFO.
  always_ff @(posedge clk_w or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        stat_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (beat_s && (owner_r == 2'(i))) begin
          stat_r[i] <= sat_inc16(stat_r[i]);
        end else begin
          stat_r[i] <= stat_r[i];
        end
      end
    end
  end

  assign stat_beats0 = stat_r[0];
  assign stat_beats1 = stat_r[1];
  assign stat_beats2 = stat_r[2];
  assign stat_beats3 = stat_r[3];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// The reference model tracks only: owner (or none), beats so far and the pointer.
// It checks every DUT output on every falling edge.
// Directed scenarios then pin the written beat sequence with literal expectations.
module tb_fifo_wr_arbiter;
  localparam int BMAX = 8;

  logic        clk_w     = 1'b0;
  logic        reset_n   = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data  = 32'h0000_0000;
  logic [3:0]  req_last  = 4'b0000;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_w;
  logic [3:0]  grant;
  logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_beats0, stat_beats1, stat_beats2, stat_beats3;
`endif

  int checks = 0;
  int errors = 0;

  // Requester sources: beats remaining, next beat index, follow-up packet, endless 1-beat mode.
  int   rem[4];
  int   idx[4];
  int   next_len[4];
  bit   reload[4];
  logic [3:0] hold_m = 4'b0000;

  // Beats actually written by the DUT: requester, index and cycle number.
  int lg_req[$];
  int lg_idx[$];
  int lg_cyc[$];
  int cyc = 0;

  // Reference model: -1 means no owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  fifo_wr_arbiter #(.BURST_MAX(BMAX)) dut (
    .clk_w       (clk_w),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_w (fifo_data_w),
    .grant       (grant),
    .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats0 (stat_beats0),
    .stat_beats1 (stat_beats1),
    .stat_beats2 (stat_beats2),
    .stat_beats3 (stat_beats3)
`endif
  );

  always #5 clk_w = ~clk_w;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (rem[i] > 0) && !hold_m[i];
      req_data[8*i +: 8]  = 8'(i * 64 + (idx[i] % 64));
      req_last[i]         = (rem[i] == 1);
    end
  endtask

  task automatic advance(input logic [3:0] acc);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        idx[i]++;
        rem[i]--;
        if (rem[i] == 0) begin
          if (reload[i]) begin
            rem[i] = 1;
          end else if (next_len[i] > 0) begin
            rem[i] = next_len[i];
            next_len[i] = 0;
          end
        end
      end
    end
  endtask

  // One clock: take the handshake seen before the edge, then present new inputs.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk_w);
    acc = req_ready & req_valid;
    @(posedge clk_w);
    #1;
    advance(acc);
    drive();
  endtask

  task automatic clear_log();
    lg_req.delete();
    lg_idx.delete();
    lg_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      idx[i] = 0;
      next_len[i] = 0;
      reload[i] = 1'b0;
    end
    hold_m    = 4'b0000;
    fifo_full = 1'b0;
    drive();
    step();
    step();
    reset_n = 1'b1;
    step();
    clear_log();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && (rem[0] + rem[1] + rem[2] + rem[3] > 0)) begin
      step();
      n++;
    end
    chk({name, "_done"}, int'(n < budget), 1);
    repeat (3) step();
  endtask

  task automatic wait_beats(input int n, input string name);
    int k;
    k = 0;
    while (lg_req.size() < n && k < 50) begin
      step();
      k++;
    end
    chk(name, int'(lg_req.size() >= n), 1);
  endtask

  // Compare process: model outputs against DUT outputs on every falling edge.
  initial begin : compare_proc
    int e_wr, e_data, e_ready, e_grant, e_busy, pick;
    forever begin
      @(negedge clk_w);
      cyc++;
      if (!reset_n) begin
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
      end
      if (m_owner >= 0) begin
        e_grant = 1 << m_owner;
        e_busy  = 1;
        e_wr    = (req_valid[m_owner] && !fifo_full) ? 1 : 0;
        e_ready = fifo_full ? 0 : (1 << m_owner);
        e_data  = int'(req_data[8*m_owner +: 8]);
      end else begin
        e_grant = 0;
        e_busy  = 0;
        e_wr    = 0;
        e_ready = 0;
        e_data  = 0;
      end
      chk("grant", int'(grant), e_grant);
      chk("busy", int'(busy), e_busy);
      chk("fifo_wr_en", int'(fifo_wr_en), e_wr);
      chk("req_ready", int'(req_ready), e_ready);
      chk("fifo_data_w", int'(fifo_data_w), e_data);
      if (fifo_wr_en === 1'b1) begin
        lg_req.push_back(int'(fifo_data_w[7:6]));
        lg_idx.push_back(int'(fifo_data_w[5:0]));
        lg_cyc.push_back(cyc);
      end
      // Advance the model with the inputs that the coming rising edge will see.
      if (reset_n) begin
        if (m_owner < 0) begin
          if (req_valid != 4'b0000) begin
            pick = -1;
            for (int k = 0; k < 4; k++) begin
              if (pick < 0 && req_valid[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
            end
            m_owner = pick;
            m_cnt   = 0;
          end
        end else if (e_wr == 1) begin
          m_cnt++;
          if (req_last[m_owner] || m_cnt == BMAX) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
          end
        end
      end
    end
  end

  initial begin : stim_proc
    // Reset state.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_data", int'(fifo_data_w), 0);
    do_reset();

    // Scenario 1: requesters 0 and 2, 3-beat packets each.
    rem[0] = 3; rem[2] = 3; drive();
    run_idle(40, "s1");
    chk("s1_count", lg_req.size(), 6);
    for (int k = 0; k < 6; k++) chk("s1_order", lg_req[k], (k < 3) ? 0 : 2);
    chk("s1_idx5", lg_idx[5], 2);
    chk("s1_gap", lg_cyc[3] - lg_cyc[2], 2);
    // Pointer now at 3: with 0 and 3 both valid, 3 goes first.
    clear_log();
    rem[0] = 1; rem[3] = 1; drive();
    run_idle(40, "s1ptr");
    chk("s1_ptr_first", lg_req[0], 3);
    chk("s1_ptr_second", lg_req[1], 0);

    // Scenario 2: 20-beat packet from 1 is cut at 8, then 3 gets its turn.
    do_reset();
    rem[1] = 20; rem[3] = 2; drive();
    run_idle(120, "s2");
    chk("s2_count", lg_req.size(), 22);
    for (int k = 0; k < 8; k++) begin
      chk("s2_req1", lg_req[k], 1);
      chk("s2_idx1", lg_idx[k], k);
    end
    chk("s2_after_cut", lg_req[8], 3);
    chk("s2_gap", lg_cyc[8] - lg_cyc[7], 2);
    chk("s2_resume_req", lg_req[10], 1);
    chk("s2_resume_idx", lg_idx[10], 8);

    // Scenario 3: FIFO full for 5 cycles after the 2nd beat of a 4-beat burst.
    do_reset();
    rem[0] = 4; drive();
    wait_beats(2, "s3_two");
    fifo_full = 1'b1;
    #1;
    chk("s3_stall_wr", int'(fifo_wr_en), 0);
    chk("s3_stall_grant", int'(grant), 1);
    repeat (5) step();
    chk("s3_held", lg_req.size(), 2);
    fifo_full = 1'b0;
    run_idle(40, "s3");
    chk("s3_count", lg_req.size(), 4);
    for (int k = 0; k < 4; k++) chk("s3_idx", lg_idx[k], k);

    // Scenario 4: all four continuously valid with 1-beat packets.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      reload[i] = 1'b1;
      rem[i] = 1;
    end
    drive();
    repeat (40) step();
    for (int i = 0; i < 4; i++) reload[i] = 1'b0;
    run_idle(40, "s4");
    for (int k = 0; k < 5; k++) chk("s4_order", lg_req[k], k % 4);
    chk("s4_period0", lg_cyc[4] - lg_cyc[0], 8);
    chk("s4_period1", lg_cyc[5] - lg_cyc[1], 8);

    // Scenario 5: reset pulse during the 3rd beat.
    do_reset();
    rem[0] = 5; drive();
    wait_beats(2, "s5_two");
    #1;
    chk("s5_third_live", int'(fifo_wr_en), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("s5_rst_wr", int'(fifo_wr_en), 0);
    chk("s5_rst_grant", int'(grant), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_ready", int'(req_ready), 0);
    chk("s5_rst_data", int'(fifo_data_w), 0);
    step();
    rem[2] = 1; drive();
    reset_n = 1'b1;
    run_idle(40, "s5");
    chk("s5_count", lg_req.size(), 6);
    chk("s5_regrant", lg_req[2], 0);
    chk("s5_retry_idx", lg_idx[2], 2);
    chk("s5_last", lg_req[5], 2);

    // Scenario 6: requester 2 sends an 8-beat packet (last meets limit) then 2 more.
    do_reset();
    rem[2] = 8; next_len[2] = 2; drive();
    run_idle(60, "s6");
    chk("s6_count", lg_req.size(), 10);
    for (int k = 0; k < 10; k++) chk("s6_req", lg_req[k], 2);
    chk("s6_gap", lg_cyc[8] - lg_cyc[7], 2);
    chk("s6_idx9", lg_idx[9], 9);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("s6_stat0", int'(stat_beats0), 0);
    chk("s6_stat1", int'(stat_beats1), 0);
    chk("s6_stat2", int'(stat_beats2), 10);
    chk("s6_stat3", int'(stat_beats3), 0);
`endif

    // Owner drops valid mid-burst while another requester waits.
    do_reset();
    rem[1] = 4; rem[2] = 1; drive();
    wait_beats(1, "s7_one");
    hold_m[1] = 1'b1; drive();
    repeat (3) step();
    chk("s7_hold_grant", int'(grant), 2);
    chk("s7_hold_busy", int'(busy), 1);
    chk("s7_hold_count", lg_req.size(), 1);
    hold_m[1] = 1'b0; drive();
    run_idle(40, "s7");
    chk("s7_count", lg_req.size(), 5);
    for (int k = 0; k < 5; k++) chk("s7_order", lg_req[k], (k < 4) ? 1 : 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 8, the maximum beats per grant (legal range 1..64).
REQ-002 SHALL have port clk_w  input  1  write-domain clock of the 64x8 async FIFO.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  4  per-requester beat valid.
REQ-005 SHALL have port req_data  input  32  per-requester beat data; requester i uses bits [8i+7:8i].
REQ-006 SHALL have port req_last  input  4  per-requester last beat of packet.
REQ-007 SHALL have port req_ready  output  4  per-requester beat accepted this cycle when valid.
REQ-008 SHALL have port fifo_full  input  1  FIFO write-side full flag.
REQ-009 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-010 SHALL have port fifo_data_w  output  8  FIFO write data.
REQ-011 SHALL have port grant  output  4  one-hot current owner, 0 when idle.
REQ-012 SHALL have port busy  output  1  high while a burst is owned.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and BURST.
REQ-014 In IDLE, when any req_valid is high, the block SHALL select the first valid requester searching upward, with wrap-around, from rr_ptr; it SHALL register the selected requester as owner and enter BURST on the next edge.
REQ-015 Arbitration latency SHALL be 1 cycle: no beat is accepted in the IDLE cycle.
REQ-016 In BURST, req_ready[owner] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-017 fifo_wr_en SHALL be combinational: req_valid[owner] & !fifo_full & (state==BURST).
REQ-018 fifo_data_w SHALL be req_data of the owner; when the block is idle, fifo_data_w SHALL be 0.
REQ-019 A beat is defined as fifo_wr_en high on a clk_w edge.
REQ-020 The beat counter SHALL increment on each beat; it is 7 bits wide and clears on entry to BURST.
REQ-021 The burst SHALL end on the beat with req_last[owner]=1, or on the beat that makes the count equal BURST_MAX, whichever comes first.
REQ-022 On burst end, the FSM SHALL return to IDLE, rr_ptr SHALL become (owner+1) mod 4, and grant SHALL clear.
REQ-023 A new arbitration SHALL always take at least 1 IDLE cycle.
REQ-024 fifo_full high SHALL stall the burst: no beat is taken, the count is held, and ownership is held.
REQ-025 The owner dropping req_valid mid-burst SHALL hold ownership; no timeout applies.
REQ-026 If the BURST_MAX cutoff and req_last occur on the same beat, the result SHALL be a single burst end with no extra effect.
REQ-027 Non-owner req_valid changes SHALL have no effect during BURST.
REQ-028 The block SHALL never assert fifo_wr_en while fifo_full is high.

Reset
REQ-029 Reset SHALL be asynchronous on reset_n low, with synchronous release on clk_w.
REQ-030 Reset values SHALL be: state=IDLE, rr_ptr=0, owner=0, count=0, grant=0, busy=0, req_ready=0, fifo_wr_en=0, fifo_data_w=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst immediately; no further beats are written after reset assertion.

Configuration
REQ-032 Macro FIFO_WR_ARB_STATS_EN SHALL control optional statistics.
REQ-033 When the macro is defined, the block SHALL add four output ports, stat_beats0..stat_beats3, each 16 bits wide.
REQ-034 Each stat_beatsN SHALL count beats from requester N, saturate at 16'hFFFF, and reset to 0.
REQ-035 When the macro is not defined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Scenario 1: req_valid=4'b0101, both requesters send 3-beat packets, fifo_full=0. Requester 0 SHALL be granted first, writing 3 beats; then 1 IDLE cycle; then requester 2 writes 3 beats; rr_ptr SHALL end at 3.
REQ-037 Scenario 2: BURST_MAX=8, requester 1 sends a 20-beat packet while requester 3 is also valid. The FIFO SHALL receive 8 beats from requester 1, then 1 IDLE cycle, then requester 3 is granted.
REQ-038 Scenario 3: fifo_full is raised for 5 cycles after the 2nd beat of a 4-beat burst. fifo_wr_en SHALL be 0 for those 5 cycles, and the FIFO SHALL receive exactly 4 beats in order with no loss or duplication.
REQ-039 Scenario 4: all 4 requesters hold valid continuously, with 1-beat packets. Grants SHALL follow the order 0,1,2,3,0 with every requester served once per 8 cycles.
REQ-040 Scenario 5: reset_n is pulsed low during the 3rd beat of a burst. All outputs SHALL be 0 within the same cycle, and after release the next grant SHALL go to requester 0 if it is valid.
REQ-041 Scenario 6 (with FIFO_WR_ARB_STATS_EN defined): requester 2 sends 10 beats. stat_beats2 SHALL read 10 and the other stat counters SHALL read 0.
